// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Arbitrates NUM_REQ write requesters onto one shared synchronous
//            FIFO. A granted requester owns the FIFO write port for a burst
//            of up to MAX_BURST words. Arbitration is round-robin by default.
//            Define FIFO_ARB_FIXED_PRIO_EN to build a fixed-priority
//            arbiter instead, where the lowest-index valid requester wins.
// Ports    : clk          - single clock, rising edge
//            rst          - synchronous active-high reset
//            req_valid    - per-requester data-valid flags [NUM_REQ]
//            req_data     - requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//            req_ready    - per-requester accept flags [NUM_REQ]
//            fifo_full    - full flag of the shared FIFO
//            fifo_w_en    - FIFO write enable (same cycle as the handshake)
//            fifo_data_in - FIFO write data (owner's word)
//            grant_id     - current owner index, meaningful while busy=1
//            busy         - high while a burst is in progress
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [2:0]                    grant_id,
  output logic                          busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [7:0] C_LAST_CNT = 8'(MAX_BURST - 1);

  state_t          r_state;
  logic [2:0]      r_owner;
  logic [2:0]      r_rr_ptr;
  logic [7:0]      r_burst_cnt;

  logic            w_active;
  logic            w_owner_valid;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic            w_xfer;
  logic            w_found;
  logic [2:0]      w_sel;

  // Reset gates the outputs directly so that a reset arriving mid-burst
  // cannot issue one more write in the cycle it is asserted.
  assign w_active = (r_state == BURST) && !rst;

  // Owner's valid flag and data word, selected with constant indices only.
  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == 3'(i)) begin
        w_owner_valid = req_valid[i];
        w_owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_xfer = w_active && w_owner_valid && !fifo_full;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_active && !fifo_full && (r_owner == 3'(i));
    end
  end

  assign fifo_w_en    = w_xfer;
  assign fifo_data_in = w_owner_data;
  assign busy         = w_active;
  assign grant_id     = rst ? 3'd0 : r_owner;

  // First valid requester searching upward from rr_ptr with wrap-around.
  // In the fixed-priority build rr_ptr is held at 0, so this same search
  // degenerates to lowest-index-wins.
  always_comb begin
    int base;
    base    = int'(r_rr_ptr);
    w_found = 1'b0;
    w_sel   = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (((base + k) % NUM_REQ) == i) && req_valid[i]) begin
          w_found = 1'b1;
          w_sel   = 3'(i);
        end
      end
    end
  end

`ifndef FIFO_ARB_FIXED_PRIO_EN
  logic [2:0] w_next_ptr;
  assign w_next_ptr = (r_owner == 3'(NUM_REQ - 1)) ? 3'd0 : r_owner + 3'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= 3'd0;
      r_rr_ptr    <= 3'd0;
      r_burst_cnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          // fifo_full deliberately does not hold off the grant.
          if (w_found) begin
            r_owner     <= w_sel;
            r_burst_cnt <= 8'd0;
            r_state     <= BURST;
          end
        end
        BURST: begin
          if (!w_owner_valid) begin
            r_state <= IDLE;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            r_rr_ptr <= w_next_ptr;
`endif
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
            if (r_burst_cnt == C_LAST_CNT) begin
              r_state <= IDLE;
`ifndef FIFO_ARB_FIXED_PRIO_EN
              r_rr_ptr <= w_next_ptr;
`endif
            end
          end
          // Owner valid but FIFO full: stall, burst and count unchanged.
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Directed self-checking bench for fifo_write_arbiter
//            (DATA_WIDTH=8, NUM_REQ=4, MAX_BURST=4). Inputs change 1 time
//            unit after a rising edge; outputs are checked 1 unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic [2:0]  grant_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  fifo_write_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .MAX_BURST  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE with rr_ptr=0, inputs idle, just after an edge.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'hA3A2A1A0;
    fifo_full = 1'b0;
    repeat (3) begin
      tick();
      #1;
      checks++;
      if (busy !== 1'b0) begin
        failures++; $display("FAIL reset_busy: got %0b expected 0", busy);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
      end
      checks++;
      if (fifo_w_en !== 1'b0) begin
        failures++; $display("FAIL reset_wen: got %0b expected 0", fifo_w_en);
      end
      checks++;
      if (grant_id !== 3'd0) begin
        failures++; $display("FAIL reset_grant: got %0d expected 0", grant_id);
      end
    end
    rst       = 1'b0;
    req_valid = 4'b0000;
    tick();
  endtask

  // Six words from requester 0: writes 1-4, one IDLE cycle, writes 5-6.
  task automatic test_single();
    logic [9:0] exp_wen;
    logic [9:0] exp_busy;
    int n;
    exp_wen  = 10'b0011011110;
    exp_busy = 10'b0111011110;
    do_reset();
    n = 1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (n <= 6) ? 4'b0001 : 4'b0000;
      req_data  = {24'h0, 8'(n)};
      #1;
      checks++;
      if (busy !== exp_busy[c]) begin
        failures++; $display("FAIL single_busy c%0d: got %0b expected %0b", c, busy, exp_busy[c]);
      end
      checks++;
      if (fifo_w_en !== exp_wen[c]) begin
        failures++; $display("FAIL single_wen c%0d: got %0b expected %0b", c, fifo_w_en, exp_wen[c]);
      end
      if (exp_wen[c]) begin
        checks++;
        if (fifo_data_in !== 8'(n)) begin
          failures++; $display("FAIL single_data c%0d: got %0h expected %0h", c, fifo_data_in, 8'(n));
        end
        checks++;
        if (req_ready !== 4'b0001) begin
          failures++; $display("FAIL single_ready c%0d: got %b expected 0001", c, req_ready);
        end
        n++;
      end
      tick();
    end
  endtask

  // All four requesters valid: grants 0,1,2,3,0, four writes each.
  task automatic test_round_robin();
    int owner;
    do_reset();
    req_data  = 32'hA3A2A1A0;
    req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      #1;
      if ((c % 5) == 0) begin
        checks++;
        if (busy !== 1'b0 || fifo_w_en !== 1'b0) begin
          failures++; $display("FAIL rr_idle c%0d: got busy=%0b wen=%0b expected 0/0", c, busy, fifo_w_en);
        end
      end else begin
        owner = (c / 5) % 4;
        checks++;
        if (grant_id !== 3'(owner)) begin
          failures++; $display("FAIL rr_grant c%0d: got %0d expected %0d", c, grant_id, owner);
        end
        checks++;
        if (fifo_w_en !== 1'b1 || fifo_data_in !== 8'(8'hA0 + owner)) begin
          failures++; $display("FAIL rr_write c%0d: got wen=%0b data=%0h expected 1/%0h", c, fifo_w_en, fifo_data_in, 8'hA0 + owner);
        end
        checks++;
        if (req_ready !== 4'(1 << owner)) begin
          failures++; $display("FAIL rr_ready c%0d: got %b expected %b", c, req_ready, 4'(1 << owner));
        end
      end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  // FIFO full for 3 cycles after the second write of a 4-word burst.
  task automatic test_back_pressure();
    logic [8:0] exp_wen;
    logic [8:0] exp_busy;
    logic [8:0] full_pat;
    int n;
    exp_wen  = 9'b011000110;
    exp_busy = 9'b011111110;
    full_pat = 9'b000111000;
    do_reset();
    n = 1;
    for (int c = 0; c < 9; c++) begin
      req_valid = (n <= 4) ? 4'b0001 : 4'b0000;
      req_data  = {24'h0, 8'(8'h50 + n)};
      fifo_full = full_pat[c];
      #1;
      checks++;
      if (busy !== exp_busy[c]) begin
        failures++; $display("FAIL bp_busy c%0d: got %0b expected %0b", c, busy, exp_busy[c]);
      end
      checks++;
      if (fifo_w_en !== exp_wen[c]) begin
        failures++; $display("FAIL bp_wen c%0d: got %0b expected %0b", c, fifo_w_en, exp_wen[c]);
      end
      checks++;
      if (req_ready !== ((exp_busy[c] && !full_pat[c]) ? 4'b0001 : 4'b0000)) begin
        failures++; $display("FAIL bp_ready c%0d: got %b", c, req_ready);
      end
      if (exp_wen[c]) begin
        checks++;
        if (fifo_data_in !== 8'(8'h50 + n)) begin
          failures++; $display("FAIL bp_data c%0d: got %0h expected %0h", c, fifo_data_in, 8'(8'h50 + n));
        end
        n++;
      end
      tick();
    end
    fifo_full = 1'b0;
  endtask

  // Owner 0 drops valid after two writes; the next grant goes to 1.
  task automatic test_early_release();
    do_reset();
    req_data  = 32'hD3D2D1D0;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL er_idle: got busy=%0b expected 0", busy);
    end
    tick();
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if (fifo_w_en !== 1'b1 || grant_id !== 3'd0 || fifo_data_in !== 8'hD0) begin
        failures++; $display("FAIL er_write c%0d: got wen=%0b grant=%0d data=%0h expected 1/0/d0", c, fifo_w_en, grant_id, fifo_data_in);
      end
      tick();
    end
    req_valid = 4'b0010;
    #1;
    checks++;
    if (fifo_w_en !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL er_drop: got wen=%0b busy=%0b expected 0/1", fifo_w_en, busy);
    end
    tick();
    req_valid = 4'b0011;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL er_gap: got busy=%0b expected 0", busy);
    end
    tick();
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 3'd1 || req_ready !== 4'b0010 || fifo_data_in !== 8'hD1) begin
      failures++; $display("FAIL er_next: got busy=%0b grant=%0d ready=%b data=%0h expected 1/1/0010/d1", busy, grant_id, req_ready, fifo_data_in);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  // A burst ends early (rr_ptr -> 3), a second burst is reset mid-way;
  // with 2 and 3 valid the next grant must come from rr_ptr=0, i.e. 2.
  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'h21, 16'h0};
    tick();
    #1;
    checks++;
    if (fifo_w_en !== 1'b1 || grant_id !== 3'd2 || fifo_data_in !== 8'h21) begin
      failures++; $display("FAIL rmb_first: got wen=%0b grant=%0d data=%0h expected 1/2/21", fifo_w_en, grant_id, fifo_data_in);
    end
    tick();
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'h22, 16'h0};
    tick();
    #1;
    checks++;
    if (fifo_w_en !== 1'b1 || grant_id !== 3'd2 || fifo_data_in !== 8'h22) begin
      failures++; $display("FAIL rmb_second: got wen=%0b grant=%0d data=%0h expected 1/2/22", fifo_w_en, grant_id, fifo_data_in);
    end
    tick();
    req_data = {8'h00, 8'h23, 16'h0};
    tick();
    req_data = {8'h00, 8'h24, 16'h0};
    rst      = 1'b1;
    #1;
    checks++;
    if (fifo_w_en !== 1'b0 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL rmb_during: got wen=%0b ready=%b expected 0/0000", fifo_w_en, req_ready);
    end
    tick();
    rst       = 1'b0;
    req_valid = 4'b1100;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000 || fifo_w_en !== 1'b0 || grant_id !== 3'd0) begin
      failures++; $display("FAIL rmb_after: got busy=%0b ready=%b wen=%0b grant=%0d expected 0/0000/0/0", busy, req_ready, fifo_w_en, grant_id);
    end
    tick();
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 3'd2) begin
      failures++; $display("FAIL rmb_regrant: got busy=%0b grant=%0d expected 1/2", busy, grant_id);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  // Requesters 1 and 3 valid: fixed priority gives 1,1,1; round-robin 1,3,1.
  task automatic test_two_requesters();
    int exp_owner [3];
`ifdef FIFO_ARB_FIXED_PRIO_EN
    exp_owner = '{1, 1, 1};
`else
    exp_owner = '{1, 3, 1};
`endif
    do_reset();
    req_data  = 32'hC3C2C1C0;
    req_valid = 4'b1010;
    for (int c = 0; c < 15; c++) begin
      #1;
      if ((c % 5) != 0) begin
        checks++;
        if (busy !== 1'b1 || grant_id !== 3'(exp_owner[c / 5])) begin
          failures++; $display("FAIL two_grant c%0d: got busy=%0b grant=%0d expected 1/%0d", c, busy, grant_id, exp_owner[c / 5]);
        end
      end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_early_release();
    test_reset_mid_burst();
    test_two_requesters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
